// File: rtl/pio_shift_out_driver.sv
// pio_shift_out_driver: watches the PIO output value and serialises every change
// (or forced resend) to a 74HC595-style shift register over SCLK/SDATA/LATCH.
module pio_shift_out_driver #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] pio_data,
    input  logic              force_update,
    output logic              ser_sclk,
    output logic              ser_data,
    output logic              ser_latch,
    output logic              busy,
    output logic [15:0]       xfer_count
);
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned PH_W  = $clog2(CLK_DIV) + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [DATA_W-1:0] last_sent, last_n;
    logic              pending, pending_n;
    logic [BIT_W-1:0]  bit_cnt, bit_n;
    logic [PH_W-1:0]   ph_cnt, ph_n;
    logic              sclk_n, data_n, latch_n, busy_n;
    logic [15:0]       count_n;
    logic              start;
    logic [DATA_W-1:0] shifted;

    // Bit presented on the line for a given shift-register content
    function automatic logic head(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? v[DATA_W-1] : v[0];
    endfunction

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shreg      <= '0;
            last_sent  <= '0;
            pending    <= 1'b1;
            bit_cnt    <= '0;
            ph_cnt     <= '0;
            ser_sclk   <= 1'b0;
            ser_data   <= 1'b0;
            ser_latch  <= 1'b0;
            busy       <= 1'b0;
            xfer_count <= '0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            last_sent  <= last_n;
            pending    <= pending_n;
            bit_cnt    <= bit_n;
            ph_cnt     <= ph_n;
            ser_sclk   <= sclk_n;
            ser_data   <= data_n;
            ser_latch  <= latch_n;
            busy       <= busy_n;
            xfer_count <= count_n;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        last_n    = last_sent;
        pending_n = pending;
        bit_n     = bit_cnt;
        ph_n      = ph_cnt;
        sclk_n    = ser_sclk;
        data_n    = ser_data;
        latch_n   = ser_latch;
        busy_n    = busy;
        count_n   = xfer_count;
        start     = pending | force_update | (pio_data != last_sent);
        shifted   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n   = SHIFT;
                    shreg_n   = pio_data;
                    last_n    = pio_data;
                    pending_n = 1'b0;
                    bit_n     = '0;
                    ph_n      = '0;
                    sclk_n    = 1'b0;
                    data_n    = head(pio_data);
                    busy_n    = 1'b1;
                end
            end
            SHIFT: begin
                pending_n = pending | force_update;
                if (ph_cnt != LAST_PH) begin
                    ph_n = ph_cnt + 1'b1;
                end else begin
                    ph_n = '0;
                    if (!ser_sclk) begin
                        sclk_n = 1'b1;
                    end else if (bit_cnt != LAST_BIT) begin
                        sclk_n  = 1'b0;
                        bit_n   = bit_cnt + 1'b1;
                        shreg_n = shifted;
                        data_n  = head(shifted);
                    end else begin
                        state_n = LATCH;
                        sclk_n  = 1'b0;
                        data_n  = 1'b0;
                        latch_n = 1'b1;
                    end
                end
            end
            LATCH: begin
                pending_n = pending | force_update;
                if (ph_cnt != LAST_PH) begin
                    ph_n = ph_cnt + 1'b1;
                end else begin
                    ph_n    = '0;
                    latch_n = 1'b0;
                    busy_n  = 1'b0;
                    count_n = xfer_count + 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pio_shift_out_driver.sv
// Testbench for pio_shift_out_driver: two instances (default and CLK_DIV=1/LSB-first),
// line monitors that rebuild frames from the serial pins, and a frame-level model.
module tb_pio_shift_out_driver;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  pio0, pio1;
    logic        force0, force1;
    logic        sclk0, sdata0, latch0, busy0;
    logic        sclk1, sdata1, latch1, busy1;
    logic [15:0] cnt0, cnt1;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_cnt0 = 16'h0;
    logic [15:0] exp_cnt1 = 16'h0;

    pio_shift_out_driver dut0 (
        .clk(clk), .reset_n(reset_n), .pio_data(pio0), .force_update(force0),
        .ser_sclk(sclk0), .ser_data(sdata0), .ser_latch(latch0), .busy(busy0),
        .xfer_count(cnt0)
    );

    pio_shift_out_driver #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .pio_data(pio1), .force_update(force1),
        .ser_sclk(sclk1), .ser_data(sdata1), .ser_latch(latch1), .busy(busy1),
        .xfer_count(cnt1)
    );

    always #5 clk = ~clk;

    // Line monitor, instance 0 (MSB first): frames, bit counts, busy/gap/latch widths
    logic [7:0] fq0[$];
    int nq0[$], bq0[$], gq0[$], lq0[$], fbq0[$];
    int rises0 = 0, hold_err0 = 0, nb0 = 0, brun0 = 0, grun0 = 0, lrun0 = 0;
    logic [7:0] acc0 = 8'h0;
    logic p_sclk0 = 1'b0, p_latch0 = 1'b0, p_busy0 = 1'b0, p_data0 = 1'b0;
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            acc0 = 8'h0; nb0 = 0; brun0 = 0; grun0 = 0; lrun0 = 0;
        end else begin
            if (sclk0 && !p_sclk0) begin
                if (nb0 == 0) fbq0.push_back(int'(sdata0));
                acc0 = {acc0[6:0], sdata0}; nb0++; rises0++;
            end
            if (busy0 && p_busy0 && (sdata0 !== p_data0) && !(p_sclk0 && !sclk0)) hold_err0++;
            if (latch0) lrun0++;
            else if (p_latch0) begin lq0.push_back(lrun0); lrun0 = 0; end
            if (latch0 && !p_latch0) begin fq0.push_back(acc0); nq0.push_back(nb0); nb0 = 0; end
            if (busy0) begin
                if (!p_busy0) gq0.push_back(grun0);
                brun0++; grun0 = 0;
            end else begin
                if (p_busy0) bq0.push_back(brun0);
                brun0 = 0; grun0++;
            end
        end
        p_sclk0 = sclk0; p_latch0 = latch0; p_busy0 = busy0; p_data0 = sdata0;
    end

    // Line monitor, instance 1 (LSB first)
    logic [7:0] fq1[$];
    int bq1[$], gq1[$], lq1[$], fbq1[$];
    int nb1 = 0, brun1 = 0, grun1 = 0, lrun1 = 0;
    logic [7:0] acc1 = 8'h0;
    logic p_sclk1 = 1'b0, p_latch1 = 1'b0, p_busy1 = 1'b0;
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            acc1 = 8'h0; nb1 = 0; brun1 = 0; grun1 = 0; lrun1 = 0;
        end else begin
            if (sclk1 && !p_sclk1) begin
                if (nb1 == 0) fbq1.push_back(int'(sdata1));
                acc1 = {sdata1, acc1[7:1]}; nb1++;
            end
            if (latch1) lrun1++;
            else if (p_latch1) begin lq1.push_back(lrun1); lrun1 = 0; end
            if (latch1 && !p_latch1) begin fq1.push_back(acc1); nb1 = 0; end
            if (busy1) begin
                if (!p_busy1) gq1.push_back(grun1);
                brun1++; grun1 = 0;
            end else begin
                if (p_busy1) bq1.push_back(brun1);
                brun1 = 0; grun1++;
            end
        end
        p_sclk1 = sclk1; p_latch1 = latch1; p_busy1 = busy1;
    end

    task automatic cycles(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic pulse_force(input int which);
        if (which == 0) force0 = 1'b1; else force1 = 1'b1;
        cycles(1);
        force0 = 1'b0; force1 = 1'b0;
    endtask

    // Wait until the chosen instance has been idle for 4 cycles; flags an expired budget
    task automatic wait_quiet(input int which, input int budget, output bit to);
        int q;
        q = 0;
        for (int i = 0; i < budget && q < 4; i++) begin
            cycles(1);
            if (((which == 0) ? busy0 : busy1) == 1'b0) q++; else q = 0;
        end
        to = (q < 4);
    endtask

    task automatic test_reset();
        bit to; int bf, bb, bl, bn;
        reset_n = 1'b0; pio0 = 8'h00; pio1 = 8'h00; force0 = 1'b0; force1 = 1'b0;
        cycles(3);
        n_checks++; if ({sclk0, sdata0, latch0, busy0, cnt0} !== 20'h0)
            $display("FAIL reset_outputs: got %h want 0", {sclk0, sdata0, latch0, busy0, cnt0}); else n_pass++;
        bf = fq0.size(); bb = bq0.size(); bl = lq0.size(); bn = nq0.size();
        reset_n = 1'b1;
        cycles(1);
        n_checks++; if (busy0 !== 1'b1) $display("FAIL reset_first_busy: got %b want 1", busy0); else n_pass++;
        wait_quiet(0, 500, to);
        n_checks++; if (to !== 1'b0) $display("FAIL reset_timeout: got %b want 0", to); else n_pass++;
        exp_cnt0 = 16'd1;
        n_checks++; if (fq0.size() - bf !== 1) $display("FAIL reset_frames: got %0d want 1", fq0.size() - bf);
        else begin n_pass++;
            n_checks++; if (fq0[bf] !== 8'h00) $display("FAIL reset_frame_val: got %h want 00", fq0[bf]); else n_pass++;
            n_checks++; if (nq0[bn] !== 8) $display("FAIL reset_frame_bits: got %0d want 8", nq0[bn]); else n_pass++;
            n_checks++; if (bq0[bb] !== 68) $display("FAIL reset_busy_len: got %0d want 68", bq0[bb]); else n_pass++;
            n_checks++; if (lq0[bl] !== 4) $display("FAIL reset_latch_len: got %0d want 4", lq0[bl]); else n_pass++;
        end
        n_checks++; if (cnt0 !== exp_cnt0) $display("FAIL reset_count: got %0d want %0d", cnt0, exp_cnt0); else n_pass++;
        wait_quiet(1, 200, to);
        exp_cnt1 = 16'd1;
        n_checks++; if (cnt1 !== exp_cnt1) $display("FAIL reset_count1: got %0d want %0d", cnt1, exp_cnt1); else n_pass++;
    endtask

    task automatic test_pattern_a5();
        bit to; int bf, bl, bfb, br;
        bf = fq0.size(); bl = lq0.size(); bfb = fbq0.size(); br = rises0;
        pio0 = 8'hA5;
        cycles(1);
        n_checks++; if (busy0 !== 1'b1) $display("FAIL a5_busy_latency: got %b want 1", busy0); else n_pass++;
        wait_quiet(0, 500, to);
        exp_cnt0 = exp_cnt0 + 16'd1;
        n_checks++; if (to !== 1'b0) $display("FAIL a5_timeout: got %b want 0", to); else n_pass++;
        n_checks++; if ((fq0.size() - bf !== 1) || (fq0[bf] !== 8'hA5))
            $display("FAIL a5_frame: got n=%0d v=%h want n=1 v=a5", fq0.size() - bf, fq0[bf]); else n_pass++;
        n_checks++; if (fbq0[bfb] !== 1) $display("FAIL a5_first_bit: got %0d want 1", fbq0[bfb]); else n_pass++;
        n_checks++; if (rises0 - br !== 8) $display("FAIL a5_sclk_rises: got %0d want 8", rises0 - br); else n_pass++;
        n_checks++; if (lq0[bl] !== 4) $display("FAIL a5_latch_len: got %0d want 4", lq0[bl]); else n_pass++;
        n_checks++; if (cnt0 !== exp_cnt0) $display("FAIL a5_count: got %0d want %0d", cnt0, exp_cnt0); else n_pass++;
    endtask

    task automatic test_midframe();
        bit to; int bf, bg;
        bf = fq0.size(); bg = gq0.size();
        pio0 = 8'h3C; cycles(10);
        pio0 = 8'h11; cycles(20);
        pio0 = 8'h81;
        wait_quiet(0, 500, to);
        exp_cnt0 = exp_cnt0 + 16'd2;
        n_checks++; if (to !== 1'b0) $display("FAIL mid_timeout: got %b want 0", to); else n_pass++;
        n_checks++; if ((fq0.size() - bf !== 2) || (fq0[bf] !== 8'h3C) || (fq0[bf+1] !== 8'h81))
            $display("FAIL mid_frames: got n=%0d %h %h want n=2 3c 81", fq0.size() - bf, fq0[bf], fq0[bf+1]); else n_pass++;
        n_checks++; if (gq0[bg+1] !== 1) $display("FAIL mid_back_to_back_gap: got %0d want 1", gq0[bg+1]); else n_pass++;
        n_checks++; if (cnt0 !== exp_cnt0) $display("FAIL mid_count: got %0d want %0d", cnt0, exp_cnt0); else n_pass++;
        n_checks++; if (hold_err0 !== 0) $display("FAIL mid_data_hold: got %0d want 0", hold_err0); else n_pass++;
    endtask

    task automatic test_force();
        bit to; int bf, br;
        bf = fq0.size();
        pio0 = 8'h5A; cycles(5);
        pulse_force(0); cycles(10);
        pulse_force(0);
        wait_quiet(0, 500, to);
        exp_cnt0 = exp_cnt0 + 16'd2;
        n_checks++; if ((to !== 1'b0) || (fq0.size() - bf !== 2) || (fq0[bf] !== 8'h5A) || (fq0[bf+1] !== 8'h5A))
            $display("FAIL force_resend: got to=%b n=%0d want to=0 n=2 5a 5a", to, fq0.size() - bf); else n_pass++;
        n_checks++; if (cnt0 !== exp_cnt0) $display("FAIL force_count: got %0d want %0d", cnt0, exp_cnt0); else n_pass++;
        bf = fq0.size(); br = rises0;
        cycles(200);
        n_checks++; if ((rises0 - br !== 0) || (fq0.size() - bf !== 0) || ({sclk0, sdata0, latch0, busy0} !== 4'h0))
            $display("FAIL no_change_idle: got rises=%0d frames=%0d want 0 0", rises0 - br, fq0.size() - bf); else n_pass++;
        bf = fq0.size();
        pio0 = 8'hC3; force0 = 1'b1; cycles(1); force0 = 1'b0;
        wait_quiet(0, 500, to);
        exp_cnt0 = exp_cnt0 + 16'd1;
        n_checks++; if ((fq0.size() - bf !== 1) || (fq0[bf] !== 8'hC3))
            $display("FAIL force_and_change: got n=%0d v=%h want n=1 v=c3", fq0.size() - bf, fq0[bf]); else n_pass++;
        n_checks++; if (cnt0 !== exp_cnt0) $display("FAIL force_and_change_count: got %0d want %0d", cnt0, exp_cnt0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit to; int bf, bf1; bit hit;
        pio0 = 8'hE7; pio1 = 8'h96;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin cycles(1); hit = (nb0 == 4); end
        n_checks++; if (hit !== 1'b1) $display("FAIL rmid_reach_bit4: got %b want 1", hit); else n_pass++;
        bf = fq0.size(); bf1 = fq1.size();
        @(posedge clk); #2; reset_n = 1'b0; #1;
        n_checks++; if ({sclk0, sdata0, latch0, busy0, cnt0, sclk1, sdata1, latch1, busy1, cnt1} !== 40'h0)
            $display("FAIL rmid_async_clear: got %h want 0",
                     {sclk0, sdata0, latch0, busy0, cnt0, sclk1, sdata1, latch1, busy1, cnt1}); else n_pass++;
        cycles(2);
        reset_n = 1'b1;
        wait_quiet(0, 500, to);
        exp_cnt0 = 16'd1;
        n_checks++; if ((to !== 1'b0) || (fq0.size() - bf !== 1) || (fq0[bf] !== 8'hE7))
            $display("FAIL rmid_refresh: got to=%b n=%0d v=%h want to=0 n=1 v=e7", to, fq0.size() - bf, fq0[bf]); else n_pass++;
        n_checks++; if (cnt0 !== exp_cnt0) $display("FAIL rmid_count: got %0d want %0d", cnt0, exp_cnt0); else n_pass++;
        wait_quiet(1, 200, to);
        exp_cnt1 = 16'd1;
        n_checks++; if ((fq1.size() - bf1 !== 1) || (fq1[bf1] !== 8'h96) || (cnt1 !== exp_cnt1))
            $display("FAIL rmid_refresh1: got n=%0d v=%h cnt=%0d want n=1 v=96 cnt=1", fq1.size() - bf1, fq1[bf1], cnt1); else n_pass++;
    endtask

    task automatic test_lsb_fast();
        bit to; int bf, bb, bl, bg, bfb;
        bf = fq1.size(); bb = bq1.size(); bl = lq1.size(); bfb = fbq1.size();
        pio1 = 8'h01;
        cycles(1);
        n_checks++; if (busy1 !== 1'b1) $display("FAIL lsb_busy_latency: got %b want 1", busy1); else n_pass++;
        wait_quiet(1, 200, to);
        exp_cnt1 = exp_cnt1 + 16'd1;
        n_checks++; if ((to !== 1'b0) || (fq1.size() - bf !== 1) || (fq1[bf] !== 8'h01))
            $display("FAIL lsb_frame: got n=%0d v=%h want n=1 v=01", fq1.size() - bf, fq1[bf]); else n_pass++;
        n_checks++; if (fbq1[bfb] !== 1) $display("FAIL lsb_first_bit: got %0d want 1", fbq1[bfb]); else n_pass++;
        n_checks++; if (bq1[bb] !== 17) $display("FAIL lsb_busy_len: got %0d want 17", bq1[bb]); else n_pass++;
        n_checks++; if (lq1[bl] !== 1) $display("FAIL lsb_latch_len: got %0d want 1", lq1[bl]); else n_pass++;
        n_checks++; if (cnt1 !== exp_cnt1) $display("FAIL lsb_count: got %0d want %0d", cnt1, exp_cnt1); else n_pass++;
        bf = fq1.size(); bg = gq1.size();
        pio1 = 8'h80; cycles(3);
        pio1 = 8'hFE;
        wait_quiet(1, 200, to);
        exp_cnt1 = exp_cnt1 + 16'd2;
        n_checks++; if ((fq1.size() - bf !== 2) || (fq1[bf] !== 8'h80) || (fq1[bf+1] !== 8'hFE))
            $display("FAIL lsb_back_to_back: got n=%0d %h %h want n=2 80 fe", fq1.size() - bf, fq1[bf], fq1[bf+1]); else n_pass++;
        n_checks++; if (gq1[bg+1] !== 1) $display("FAIL lsb_gap: got %0d want 1", gq1[bg+1]); else n_pass++;
        n_checks++; if (cnt1 !== exp_cnt1) $display("FAIL lsb_b2b_count: got %0d want %0d", cnt1, exp_cnt1); else n_pass++;
    endtask

    // Random writes/forces on instance 0 against a frame-level model: after going
    // idle the last sent value equals pio_data; a frame starts on change or force,
    // and mid-frame activity yields one trailing frame of the final value.
    task automatic test_random();
        bit to; int bf, mode, k; bit f, fb;
        logic [7:0] last_m, v, vf;
        logic [7:0] expq[$];
        for (int it = 0; it < 12; it++) begin
            last_m = pio0;
            expq.delete();
            bf = fq0.size();
            v = 8'($urandom_range(0, 255));
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                if ($urandom_range(0, 1) == 1) v = last_m;
                f = ($urandom_range(0, 1) == 1);
                pio0 = v; force0 = f; cycles(1); force0 = 1'b0;
                if ((v != last_m) || f) expq.push_back(v);
            end else begin
                if (v == last_m) v = v ^ 8'h01;
                pio0 = v; cycles(2);
                expq.push_back(v);
                k = $urandom_range(1, 3); fb = 1'b0; vf = v;
                for (int j = 0; j < k; j++) begin
                    cycles($urandom_range(3, 15));
                    vf = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 3) == 0) begin pio0 = vf; pulse_force(0); fb = 1'b1; end
                    else pio0 = vf;
                end
                if ((vf != v) || fb) expq.push_back(vf);
            end
            wait_quiet(0, 1000, to);
            exp_cnt0 = exp_cnt0 + 16'(expq.size());
            n_checks++; if ((to !== 1'b0) || (fq0.size() - bf !== expq.size()))
                $display("FAIL rand_%0d_frames: got to=%b n=%0d want to=0 n=%0d", it, to, fq0.size() - bf, expq.size());
            else begin
                n_pass++;
                for (int j = 0; j < expq.size(); j++) begin
                    n_checks++; if (fq0[bf+j] !== expq[j])
                        $display("FAIL rand_%0d_val%0d: got %h want %h", it, j, fq0[bf+j], expq[j]); else n_pass++;
                end
            end
            n_checks++; if (cnt0 !== exp_cnt0) $display("FAIL rand_%0d_count: got %0d want %0d", it, cnt0, exp_cnt0); else n_pass++;
        end
        n_checks++; if (hold_err0 !== 0) $display("FAIL rand_data_hold: got %0d want 0", hold_err0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pattern_a5();
        test_midframe();
        test_force();
        test_reset_mid();
        test_lsb_fast();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
